strip_ctrl: RTL and testbench

User-interface controller and parameter sequencer for the channel strip. Three front-panel buttons select a parameter field and step its value. Every selection change to the sine generator, lowpass or highpass is applied through a mute → apply → settle sequence, so the datapath never switches coefficients or frequency while audible. Sits between the board buttons and the freq/lowpass/highpass select inputs. Also drives mute into the output stage and the edited field/value into the display path.

---
 rtl/strip_pkg.sv | 41 ++++
 rtl/strip_ctrl_if.sv | 26 ++
 rtl/strip_ctrl_btn_debounce.sv | 46 ++++
 rtl/strip_ctrl.sv | 143 ++++++++++++++
 tb/tb_strip_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/strip_pkg.sv
// Shared types and helpers for the channel-strip UI controller.
// The field and sequencer-state encodings are fixed here so every file agrees on them.
package strip_pkg;

  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    FREQ = 2'd0,
    LP   = 2'd1,
    HP   = 2'd2
  } field_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MUTE   = 2'd1,
    APPLY  = 2'd2,
    SETTLE = 2'd3
  } state_t;

  function automatic field_t next_field(input field_t f);
    case (f)
      FREQ:    next_field = LP;
      LP:      next_field = HP;
      HP:      next_field = FREQ;
      default: next_field = FREQ;
    endcase
  endfunction

  function automatic logic [SEL_W-1:0] pick_sel(input field_t f,
                                                input logic [SEL_W-1:0] fq,
                                                input logic [SEL_W-1:0] lp,
                                                input logic [SEL_W-1:0] hp);
    case (f)
      FREQ:    pick_sel = fq;
      LP:      pick_sel = lp;
      HP:      pick_sel = hp;
      default: pick_sel = fq;
    endcase
  endfunction

endpackage

// File: rtl/strip_ctrl_if.sv
// Front-panel buttons in, datapath selects / mute / display fields out.
interface strip_ctrl_if;
  import strip_pkg::*;

  logic             btn_mode;
  logic             btn_up;
  logic             btn_down;
  logic [SEL_W-1:0] freq_sel;
  logic [SEL_W-1:0] lp_sel;
  logic [SEL_W-1:0] hp_sel;
  logic             mute;
  logic             busy;
  logic [1:0]       edit_field;
  logic [SEL_W-1:0] edit_value;

  modport master (
    output btn_mode, btn_up, btn_down,
    input  freq_sel, lp_sel, hp_sel, mute, busy, edit_field, edit_value
  );

  modport slave (
    input  btn_mode, btn_up, btn_down,
    output freq_sel, lp_sel, hp_sel, mute, busy, edit_field, edit_value
  );

endinterface

// File: rtl/strip_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, 1-cycle press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 480
) (
  input  logic clk_48,
  input  logic reset_n,
  input  logic btn_raw,
  output logic pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             level_r;
  logic             pulse_r;
  logic [CNT_W-1:0] cnt_r;

  // Level flips only after DEBOUNCE_CYCLES consecutive samples disagreeing with it.
  always_ff @(posedge clk_48) begin
    if (!reset_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      level_r <= 1'b0;
      pulse_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      sync1_r <= btn_raw;
      sync2_r <= sync1_r;
      pulse_r <= 1'b0;
      if (sync2_r == level_r) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_r == CNT_LAST) begin
        level_r <= sync2_r;
        cnt_r   <= {CNT_W{1'b0}};
        pulse_r <= sync2_r;
      end else begin
        cnt_r <= cnt_r + 1'b1;
      end
    end
  end

  assign pulse = pulse_r;

endmodule

// File: rtl/strip_ctrl.sv
// Channel-strip UI controller: field select, value stepping and the
// mute -> apply -> settle sequencer that hides select changes from the listener.
module strip_ctrl
  import strip_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 480,
  parameter int MUTE_CYCLES     = 64,
  parameter int SETTLE_CYCLES   = 256,
  parameter int SEL_MAX         = 7,
  parameter int FREQ_INIT       = 4,
  parameter int LP_INIT         = 1,
  parameter int HP_INIT         = 3
) (
  input  logic         clk_48,
  input  logic         reset_n,
  strip_ctrl_if.slave  bus
);

  localparam int TMR_MAX = (MUTE_CYCLES > SETTLE_CYCLES) ? MUTE_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] MUTE_LAST   = TMR_W'(MUTE_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ZERO    = TMR_W'(0);
  localparam logic [SEL_W-1:0] SEL_MAX_V   = SEL_W'(SEL_MAX);
  localparam logic [SEL_W-1:0] SEL_ZERO    = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_ONE     = SEL_W'(1);

  logic mode_ev_s, up_ev_s, down_ev_s;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk_48(clk_48), .reset_n(reset_n), .btn_raw(bus.btn_mode), .pulse(mode_ev_s));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk_48(clk_48), .reset_n(reset_n), .btn_raw(bus.btn_up), .pulse(up_ev_s));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk_48(clk_48), .reset_n(reset_n), .btn_raw(bus.btn_down), .pulse(down_ev_s));

  state_t           state_r;
  field_t           edit_field_r, tgt_field_r, field_nxt_s;
  logic [TMR_W-1:0] tmr_r;
  logic             mute_r, busy_r, start_s;
  logic [SEL_W-1:0] freq_sel_r, lp_sel_r, hp_sel_r, edit_value_r, tgt_val_r;
  logic [SEL_W-1:0] cur_val_s, tgt_nxt_s, freq_nxt_s, lp_nxt_s, hp_nxt_s, value_nxt_s;

  // Next field/select values; edit_value is registered from these so it never lags.
  always_comb begin
    field_nxt_s = edit_field_r;
    cur_val_s   = pick_sel(edit_field_r, freq_sel_r, lp_sel_r, hp_sel_r);
    start_s     = 1'b0;
    tgt_nxt_s   = cur_val_s;
    if (mode_ev_s) begin
      field_nxt_s = next_field(edit_field_r);
    end else begin
      field_nxt_s = edit_field_r;
    end
    if (state_r == IDLE && !mode_ev_s && up_ev_s && !down_ev_s && cur_val_s < SEL_MAX_V) begin
      start_s   = 1'b1;
      tgt_nxt_s = cur_val_s + SEL_ONE;
    end else if (state_r == IDLE && !mode_ev_s && down_ev_s && !up_ev_s && cur_val_s > SEL_ZERO) begin
      start_s   = 1'b1;
      tgt_nxt_s = cur_val_s - SEL_ONE;
    end else begin
      start_s   = 1'b0;
      tgt_nxt_s = cur_val_s;
    end
    if (state_r == APPLY && tgt_field_r == FREQ) freq_nxt_s = tgt_val_r;
    else                                         freq_nxt_s = freq_sel_r;
    if (state_r == APPLY && tgt_field_r == LP)   lp_nxt_s = tgt_val_r;
    else                                         lp_nxt_s = lp_sel_r;
    if (state_r == APPLY && tgt_field_r == HP)   hp_nxt_s = tgt_val_r;
    else                                         hp_nxt_s = hp_sel_r;
    value_nxt_s = pick_sel(field_nxt_s, freq_nxt_s, lp_nxt_s, hp_nxt_s);
  end

  // Sequencer with registered outputs; mute spans MUTE + APPLY + SETTLE exactly.
  always_ff @(posedge clk_48) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      tmr_r        <= TMR_ZERO;
      mute_r       <= 1'b0;
      busy_r       <= 1'b0;
      edit_field_r <= FREQ;
      tgt_field_r  <= FREQ;
      tgt_val_r    <= SEL_ZERO;
      freq_sel_r   <= SEL_W'(FREQ_INIT);
      lp_sel_r     <= SEL_W'(LP_INIT);
      hp_sel_r     <= SEL_W'(HP_INIT);
      edit_value_r <= SEL_W'(FREQ_INIT);
    end else begin
      edit_field_r <= field_nxt_s;
      freq_sel_r   <= freq_nxt_s;
      lp_sel_r     <= lp_nxt_s;
      hp_sel_r     <= hp_nxt_s;
      edit_value_r <= value_nxt_s;
      case (state_r)
        IDLE: begin
          if (start_s) begin
            state_r     <= MUTE;
            tmr_r       <= MUTE_LAST;
            mute_r      <= 1'b1;
            busy_r      <= 1'b1;
            tgt_field_r <= edit_field_r;
            tgt_val_r   <= tgt_nxt_s;
          end else begin
            state_r <= IDLE;
            mute_r  <= 1'b0;
            busy_r  <= 1'b0;
          end
        end
        MUTE: begin
          if (tmr_r == TMR_ZERO) state_r <= APPLY;
          else                   tmr_r   <= tmr_r - 1'b1;
        end
        APPLY: begin
          state_r <= SETTLE;
          tmr_r   <= SETTLE_LAST;
        end
        SETTLE: begin
          if (tmr_r == TMR_ZERO) begin
            state_r <= IDLE;
            mute_r  <= 1'b0;
            busy_r  <= 1'b0;
          end else begin
            tmr_r <= tmr_r - 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          mute_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.freq_sel   = freq_sel_r;
  assign bus.lp_sel     = lp_sel_r;
  assign bus.hp_sel     = hp_sel_r;
  assign bus.mute       = mute_r;
  assign bus.busy       = busy_r;
  assign bus.edit_field = edit_field_r;
  assign bus.edit_value = edit_value_r;

endmodule

// File: tb/tb_strip_ctrl.sv
// Bench for strip_ctrl: directed vector table, hand sequences for timing corners,
// and random button presses scored against an event-level reference model.
module tb_strip_ctrl;
  import strip_pkg::*;

  localparam int DEB = 4;
  localparam int MC  = 3;
  localparam int SC  = 5;
  localparam int SEQ = MC + 1 + SC;

  logic clk_48 = 1'b0;
  logic reset_n;
  strip_ctrl_if bus();

  strip_ctrl #(
    .DEBOUNCE_CYCLES(DEB), .MUTE_CYCLES(MC), .SETTLE_CYCLES(SC),
    .SEL_MAX(7), .FREQ_INIT(4), .LP_INIT(1), .HP_INIT(3)
  ) dut (
    .clk_48(clk_48),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk_48 = ~clk_48;

  int n_tests = 0;
  int n_fail  = 0;
  int m_sel[3];
  int m_field;

  typedef struct packed {
    logic [2:0] mask;   // {mode, up, down}
    int         freq;
    int         lp;
    int         hp;
    int         field;
    int         mute;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_48);
    #1;
  endtask

  task automatic set_btns(input logic [2:0] m);
    bus.btn_mode = m[2];
    bus.btn_up   = m[1];
    bus.btn_down = m[0];
  endtask

  task automatic model_reset();
    m_sel[0] = 4; m_sel[1] = 1; m_sel[2] = 3; m_field = 0;
  endtask

  // Event-level rules: mode wins, up+down cancel, saturate at the ends.
  task automatic model_press(input logic [2:0] m, output int exp_mute);
    exp_mute = 0;
    if (m[2]) begin
      m_field = (m_field + 1) % 3;
    end else if (m[1] && !m[0]) begin
      if (m_sel[m_field] < 7) begin m_sel[m_field]++; exp_mute = SEQ; end
    end else if (m[0] && !m[1]) begin
      if (m_sel[m_field] > 0) begin m_sel[m_field]--; exp_mute = SEQ; end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_freq"},  int'(bus.freq_sel), m_sel[0]);
    check({tag, "_lp"},    int'(bus.lp_sel),   m_sel[1]);
    check({tag, "_hp"},    int'(bus.hp_sel),   m_sel[2]);
    check({tag, "_field"}, int'(bus.edit_field), m_field);
    check({tag, "_value"}, int'(bus.edit_value), m_sel[m_field]);
    check({tag, "_mute"},  int'(bus.mute), 0);
    check({tag, "_busy"},  int'(bus.busy), 0);
  endtask

  task automatic sample(input logic [8:0] s0, inout int mcnt, inout int bcnt, inout int aidx);
    if (bus.mute) mcnt++;
    if (bus.busy) bcnt++;
    if (aidx == 0 && {bus.freq_sel, bus.lp_sel, bus.hp_sel} != s0) aidx = mcnt;
  endtask

  // Hold a button pattern, release, wait for idle; report mute/busy length and
  // the mute cycle on which a select first changed.
  task automatic press(input logic [2:0] m, input int hold,
                       output int mcnt, output int bcnt, output int aidx);
    logic [8:0] s0;
    bit done;
    s0 = {bus.freq_sel, bus.lp_sel, bus.hp_sel};
    mcnt = 0; bcnt = 0; aidx = 0; done = 1'b0;
    set_btns(m);
    for (int i = 0; i < hold; i++) begin
      step();
      sample(s0, mcnt, bcnt, aidx);
    end
    set_btns(3'b000);
    for (int i = 0; i < 400 && !done; i++) begin
      step();
      sample(s0, mcnt, bcnt, aidx);
      if (i >= 2 * DEB + 4 && !bus.busy) done = 1'b1;
    end
    if (!done) check("press_timeout", 0, 1);
  endtask

  task automatic check_press(input string tag, input int exp_mute,
                             input int mcnt, input int bcnt, input int aidx);
    check({tag, "_mute_len"}, mcnt, exp_mute);
    check({tag, "_busy_len"}, bcnt, exp_mute);
    check({tag, "_apply_at"}, aidx, (exp_mute == SEQ) ? MC + 2 : 0);
  endtask

  initial begin
    int mcnt, bcnt, aidx, em, r;
    logic [2:0] m;
    bit mode_set, fld_seen, fld_in_mute, rst_done;

    vecs = '{
      '{3'b010, 5, 1, 3, 0, SEQ}, '{3'b100, 5, 1, 3, 1, 0},
      '{3'b100, 5, 1, 3, 2, 0},   '{3'b001, 5, 1, 2, 2, SEQ},
      '{3'b100, 5, 1, 2, 0, 0},   '{3'b100, 5, 1, 2, 1, 0},
      '{3'b010, 5, 2, 2, 1, SEQ}, '{3'b010, 5, 3, 2, 1, SEQ},
      '{3'b010, 5, 4, 2, 1, SEQ}, '{3'b010, 5, 5, 2, 1, SEQ},
      '{3'b010, 5, 6, 2, 1, SEQ}, '{3'b010, 5, 7, 2, 1, SEQ},
      '{3'b010, 5, 7, 2, 1, 0},   '{3'b011, 5, 7, 2, 1, 0},
      '{3'b110, 5, 7, 2, 2, 0},   '{3'b001, 5, 7, 1, 2, SEQ},
      '{3'b001, 5, 7, 0, 2, SEQ}, '{3'b001, 5, 7, 0, 2, 0},
      '{3'b100, 5, 7, 0, 0, 0},   '{3'b101, 5, 7, 0, 1, 0}
    };

    set_btns(3'b000);
    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    repeat (20) step();
    model_reset();
    check_model("reset");

    // Short glitch must not reach the sequencer.
    mcnt = 0;
    set_btns(3'b010);
    repeat (2) step();
    set_btns(3'b000);
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.mute) mcnt++;
    end
    check("glitch_mute", mcnt, 0);
    check_model("glitch");

    foreach (vecs[i]) begin
      press(vecs[i].mask, 10, mcnt, bcnt, aidx);
      model_press(vecs[i].mask, em);
      check_press($sformatf("vec%0d", i), vecs[i].mute, mcnt, bcnt, aidx);
      check($sformatf("vec%0d_freq", i),  int'(bus.freq_sel), vecs[i].freq);
      check($sformatf("vec%0d_lp", i),    int'(bus.lp_sel),   vecs[i].lp);
      check($sformatf("vec%0d_hp", i),    int'(bus.hp_sel),   vecs[i].hp);
      check($sformatf("vec%0d_field", i), int'(bus.edit_field), vecs[i].field);
      check($sformatf("vec%0d_value", i), int'(bus.edit_value),
            (vecs[i].field == 0) ? vecs[i].freq : (vecs[i].field == 1) ? vecs[i].lp : vecs[i].hp);
    end

    // Down accepted, up one cycle later lands in MUTE and is dropped.
    set_btns(3'b001);
    step();
    press(3'b011, 9, mcnt, bcnt, aidx);
    model_press(3'b001, em);
    check_press("drop_busy", SEQ, mcnt + (bus.mute ? 1 : 0), bcnt, aidx);
    check_model("drop_busy");

    // Mode pressed while the sequence runs: field moves, target still applied.
    mode_set = 1'b0; fld_seen = 1'b0; fld_in_mute = 1'b0; mcnt = 0;
    set_btns(3'b001);
    for (int i = 0; i < 60; i++) begin
      step();
      if (bus.mute) mcnt++;
      if (mcnt == 2 && !mode_set) begin set_btns(3'b101); mode_set = 1'b1; end
      if (i == 16) set_btns(3'b000);
      if (!fld_seen && int'(bus.edit_field) == 2) begin
        fld_seen = 1'b1;
        fld_in_mute = bus.mute;
        check("mid_seq_value", int'(bus.edit_value), int'(bus.hp_sel));
      end
    end
    model_press(3'b001, em);
    model_press(3'b100, em);
    check("mid_seq_field_in_mute", int'(fld_in_mute), 1);
    check("mid_seq_mute_len", mcnt, SEQ);
    check_model("mid_seq");

    // Reset during SETTLE, after the new value has been applied.
    mcnt = 0; rst_done = 1'b0;
    set_btns(3'b010);
    for (int i = 0; i < 40 && !rst_done; i++) begin
      step();
      if (bus.mute) mcnt++;
      if (mcnt == MC + 4) begin
        check("pre_reset_hp", int'(bus.hp_sel), 1);
        set_btns(3'b000);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        rst_done = 1'b1;
      end
    end
    check("reset_reached", int'(rst_done), 1);
    model_reset();
    check_model("abort_now");
    repeat (20) step();
    check_model("abort_later");

    // Random presses against the event-level model.
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r < 3)      m = 3'b100;
      else if (r < 6) m = 3'b010;
      else if (r < 9) m = 3'b001;
      else            m = 3'($urandom_range(1, 7));
      press(m, $urandom_range(DEB + 2, 12), mcnt, bcnt, aidx);
      model_press(m, em);
      check_press($sformatf("rnd%0d_m%0b", n, m), em, mcnt, bcnt, aidx);
      check_model($sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
